// File: rtl/commit_tracker.sv
// commit_tracker: turns raw writeback state into at most one commit record per cycle,
// with stall dedup, halt-trap capture and cycle/retired-instruction counters.
module commit_tracker #(
  parameter logic [31:0] TRAP_INST = 32'h0000006b,
  parameter bit          DEDUP     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [63:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_wen,
  input  logic [4:0]  wb_wdest,
  input  logic [63:0] wb_wdata,
  input  logic [63:0] a0_value,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic        commit_wen,
  output logic [7:0]  commit_wdest,
  output logic [63:0] commit_wdata,
  output logic        trap_valid,
  output logic [2:0]  trap_code,
  output logic [63:0] trap_pc,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instr_cnt
);
  typedef enum logic {RUN, HALT} state_e;
  state_e      state;
  logic [63:0] lastPc;
  logic        lastPcValid;
  logic        held;
  logic        bubble;
  logic        dup;
  logic        accept;
  always_comb begin
    bubble = !wb_valid || wb_inst == '0;
    dup    = DEDUP && lastPcValid && held && wb_pc == lastPc;
    accept = state == RUN && !bubble && !dup;
  end
  // held: wb_valid (with a real instruction) unbroken since the last accept
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      lastPc       <= '0;
      lastPcValid  <= 1'b0;
      held         <= 1'b0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_wen   <= 1'b0;
      commit_wdest <= '0;
      commit_wdata <= '0;
      trap_valid   <= 1'b0;
      trap_code    <= '0;
      trap_pc      <= '0;
      cycle_cnt    <= '0;
      instr_cnt    <= '0;
    end else begin
      commit_valid <= accept;
      if (state == RUN) cycle_cnt <= cycle_cnt + 64'd1;
      if (accept) begin
        commit_pc    <= wb_pc;
        commit_inst  <= wb_inst;
        commit_wen   <= wb_wen && wb_wdest != '0;
        commit_wdest <= {3'b000, wb_wdest};
        commit_wdata <= wb_wdata;
        instr_cnt    <= instr_cnt + 64'd1;
        lastPc       <= wb_pc;
        lastPcValid  <= 1'b1;
        held         <= 1'b1;
        if (wb_inst == TRAP_INST) begin
          state      <= HALT;
          trap_valid <= 1'b1;
          trap_code  <= a0_value[2:0];
          trap_pc    <= wb_pc;
        end
      end else if (bubble) begin
        held <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_commit_tracker.sv
// tb_commit_tracker: runs DEDUP=0 and DEDUP=1 instances side by side against a
// behavioural model, plus literal checks for the directed scenarios.
module tb_commit_tracker;
  localparam logic [31:0] TRAP = 32'h0000006b;
  localparam logic [31:0] ADDI = 32'h00100093;
  typedef struct packed {
    logic        cv;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        tv;
    logic [2:0]  tcode;
    logic [63:0] tpc;
    logic [63:0] cyc;
    logic [63:0] ins;
  } out_t;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [63:0] wb_pc = '0;
  logic [31:0] wb_inst = '0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_wdest = '0;
  logic [63:0] wb_wdata = '0;
  logic [63:0] a0_value = '0;
  out_t        act [2];
  out_t        expd [2];
  logic        mHalt [2];
  logic        mHave [2];
  logic        mUnbroken [2];
  logic [63:0] mLast [2];
  int          pulses [2];
  int          errors = 0;
  int          checks = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 2; g++) begin : dut
    logic        cv, wen, tv;
    logic [63:0] pc, wdata, tpc, cyc, ins;
    logic [31:0] inst;
    logic [7:0]  wdest;
    logic [2:0]  tcode;
    commit_tracker #(.TRAP_INST(TRAP), .DEDUP(g == 1)) u (
      .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
      .wb_inst(wb_inst), .wb_wen(wb_wen), .wb_wdest(wb_wdest),
      .wb_wdata(wb_wdata), .a0_value(a0_value),
      .commit_valid(cv), .commit_pc(pc), .commit_inst(inst), .commit_wen(wen),
      .commit_wdest(wdest), .commit_wdata(wdata), .trap_valid(tv),
      .trap_code(tcode), .trap_pc(tpc), .cycle_cnt(cyc), .instr_cnt(ins));
    assign act[g] = {cv, pc, inst, wen, wdest, wdata, tv, tcode, tpc, cyc, ins};
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask
  // Reference: next-cycle outputs derived from the commit rules on the current inputs.
  task automatic model(input int d);
    logic dup, acc;
    if (reset) begin
      expd[d] = '0;
      mHalt[d] = 0;
      mHave[d] = 0;
      mUnbroken[d] = 0;
      mLast[d] = '0;
      return;
    end
    dup = d == 1 && mHave[d] && mUnbroken[d] && wb_pc == mLast[d];
    acc = !mHalt[d] && wb_valid && wb_inst != 0 && !dup;
    expd[d].cv = acc;
    if (!mHalt[d]) expd[d].cyc = expd[d].cyc + 1;
    if (acc) begin
      expd[d].pc = wb_pc;
      expd[d].inst = wb_inst;
      expd[d].wen = wb_wen && wb_wdest != 0;
      expd[d].wdest = {3'b000, wb_wdest};
      expd[d].wdata = wb_wdata;
      expd[d].ins = expd[d].ins + 1;
      mLast[d] = wb_pc;
      mHave[d] = 1;
      mUnbroken[d] = 1;
      if (wb_inst == TRAP) begin
        mHalt[d] = 1;
        expd[d].tv = 1;
        expd[d].tcode = a0_value[2:0];
        expd[d].tpc = wb_pc;
      end
    end else if (!wb_valid || wb_inst == 0) begin
      mUnbroken[d] = 0;
    end
  endtask
  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                      input logic w, input logic [4:0] wd, input logic [63:0] a0,
                      input logic r);
    wb_valid = v;
    wb_pc = pc;
    wb_inst = inst;
    wb_wen = w;
    wb_wdest = wd;
    wb_wdata = {pc[31:0], inst};
    a0_value = a0;
    reset = r;
    for (int d = 0; d < 2; d++) model(d);
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act[d] !== expd[d]) begin
        errors++;
        $display("FAIL model dedup=%0d: got %h, want %h", d, act[d], expd[d]);
      end
      pulses[d] += int'(act[d].cv);
    end
  endtask
  initial begin
    int p0, p1;
    logic [63:0] c, n;
    pulses[0] = 0;
    pulses[1] = 0;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("reset_zero", 64'(act[1] != '0), 0);
    // basic stream
    step(1, 64'h80000000, ADDI, 1, 1, 0, 0);
    chk("first_pc", act[1].pc, 64'h80000000);
    step(1, 64'h80000004, ADDI, 1, 1, 0, 0);
    step(1, 64'h80000008, ADDI, 1, 1, 0, 0);
    chk("basic_pc3", act[1].pc, 64'h80000008);
    chk("basic_instr", act[1].ins, 3);
    chk("basic_cycle", act[1].cyc, 3);
    chk("basic_pulses", pulses[1], 3);
    // stall hold
    p0 = pulses[0]; p1 = pulses[1];
    repeat (4) step(1, 64'h80000010, ADDI, 1, 2, 0, 0);
    chk("stall_dedup1", pulses[1] - p1, 1);
    chk("stall_dedup0", pulses[0] - p0, 4);
    // bubble and x0 write
    step(1, 64'h80000040, 0, 1, 3, 0, 0);
    chk("bubble_cv", act[1].cv, 0);
    step(1, 64'h80000030, ADDI, 1, 0, 0, 0);
    chk("x0_cv", act[1].cv, 1);
    chk("x0_wen", act[1].wen, 0);
    chk("x0_wdest", act[1].wdest, 0);
    // self-loop re-entry
    p1 = pulses[1];
    step(1, 64'h80000020, ADDI, 1, 4, 0, 0);
    step(0, 64'h80000020, ADDI, 1, 4, 0, 0);
    step(1, 64'h80000020, ADDI, 1, 4, 0, 0);
    chk("reentry", pulses[1] - p1, 2);
    // trap
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 64'h80000000, ADDI, 1, 1, 64'h5, 0);
    step(1, 64'h80000100, TRAP, 0, 0, 0, 0);
    chk("trap_cv", act[1].cv, 1);
    chk("trap_valid", act[1].tv, 1);
    chk("trap_code", act[1].tcode, 0);
    chk("trap_pc", act[1].tpc, 64'h80000100);
    chk("trap_instr", act[1].ins, 2);
    c = act[1].cyc; n = act[1].ins; p1 = pulses[1];
    for (int i = 0; i < 5; i++) step(1, 64'h80000200 + 64'(4 * i), ADDI, 1, 5, 64'h3, 0);
    chk("halt_cycle", act[1].cyc, c);
    chk("halt_instr", act[1].ins, n);
    chk("halt_pulses", pulses[1] - p1, 0);
    // reset while halted, then same pc is not a duplicate
    step(1, 64'h80000100, ADDI, 1, 1, 0, 1);
    chk("halt_reset", 64'(act[1] != '0), 0);
    step(1, 64'h80000100, ADDI, 1, 1, 0, 0);
    chk("post_reset_cv", act[1].cv, 1);
    step(1, 64'h80000104, ADDI, 1, 1, 0, 1);
    chk("mid_reset", 64'(act[0] != '0), 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] inst;
      logic [63:0] pc;
      pc = ($urandom_range(0, 9) == 0) ? 64'h0 : 64'h80000000 + 64'(4 * $urandom_range(0, 3));
      inst = ($urandom_range(0, 7) == 0) ? 32'h0 :
             ($urandom_range(0, 60) == 0) ? TRAP : ($urandom | 32'h1);
      step(($urandom_range(0, 3) != 0), pc, inst, 1'($urandom), 5'($urandom),
           {$urandom, $urandom}, ($urandom_range(0, 150) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_tracker.md
# commit_tracker

Registered commit stage between the core's writeback signals and the difftest commit, trap and performance probes in the simulation top. Each cycle it turns the raw writeback state (pc, instruction, register write) into at most one clean commit record. It filters bubbles and stall-held duplicates, detects the halt trap instruction, and keeps cycle and retired-instruction counters. Once the trap is committed it freezes until reset.

## Interface
Parameters:
- TRAP_INST, 32'h0000006b, instruction encoding that halts simulation
- DEDUP, 1, 1 = suppress writeback held unchanged across stall cycles; 0 = every qualified wb_valid cycle commits

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback stage holds an instruction this cycle
- wb_pc  in  64  writeback pc
- wb_inst  in  32  writeback instruction word
- wb_wen  in  1  instruction writes a GPR
- wb_wdest  in  5  destination GPR index
- wb_wdata  in  64  value written to GPR
- a0_value  in  64  current GPR x10, source of the trap code
- commit_valid  out  1  one-cycle pulse per committed instruction
- commit_pc  out  64  committed pc
- commit_inst  out  32  committed instruction
- commit_wen  out  1  committed GPR write enable
- commit_wdest  out  8  destination index, zero-extended
- commit_wdata  out  64  written value
- trap_valid  out  1  level, high once trap committed
- trap_code  out  3  a0_value[2:0] captured at trap
- trap_pc  out  64  pc of trap instruction
- cycle_cnt  out  64  cycles spent in RUN
- instr_cnt  out  64  instructions committed

## Operation
- States: RUN (reset state), HALT. RUN -> HALT on accepting an instruction equal to TRAP_INST. HALT is left only by reset.
- Accept condition (RUN only): wb_valid=1 and wb_inst!=0 and not duplicate.
- Duplicate (DEDUP=1 only): wb_pc equals the last accepted pc, and wb_valid has been 1 on every cycle since that accept. Any cycle with wb_valid=0 or wb_inst=0 clears the hold tracking. The last-accepted-pc register is valid-flagged and cleared by reset, so the first instruction is never a duplicate, including pc 0.
- On accept, the next cycle drives:
  - commit_valid=1
  - commit_pc/inst/wdata copied from the wb_* inputs
  - commit_wdest = {3'b0, wb_wdest}
  - commit_wen = wb_wen & (wb_wdest!=0); x0 writes never reported
- Not accepted: commit_valid=0 next cycle. The other commit_* fields hold their previous values.
- Trap accept also:
  - captures trap_code=a0_value[2:0] and trap_pc=wb_pc from the same cycle
  - sets trap_valid the next cycle, in the same cycle as that instruction's commit_valid
  - the trap instruction itself is committed and counted
- cycle_cnt: +1 every cycle in RUN, including the cycle the trap is accepted. Frozen in HALT.
- instr_cnt: +1 per accept. Frozen in HALT.
- Both counters are 64-bit and wrap modulo 2^64 with no flag.
- HALT: no accepts; commit_valid=0; all trap_* and counter outputs hold.

## Timing
- Reset (synchronous): every output 0, state RUN, last-pc valid flag 0, hold tracking cleared.
- Reset mid-operation wins over any same-cycle accept. The following cycle shows all outputs 0.
- Latency: exactly 1 cycle from accept to commit_valid. Throughput: one commit per cycle.
- commit_valid never high two cycles for the same held writeback when DEDUP=1.
- Counters are registered. Cycle N after reset release reads cycle_cnt=N-1 in RUN, i.e. the first RUN cycle reads 0.
- Same-cycle trap and accept: a single accept only; there is no separate trap path.

## Test plan
- Basic stream: wb_valid=1 with pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, inst 0x00100093 -> three commit_valid pulses one cycle later with matching pcs; instr_cnt=3.
- Stall hold, DEDUP=1: pc 0x80000010 held with wb_valid=1 for 4 cycles -> exactly 1 commit. With DEDUP=0 -> 4 commits.
- Bubble / x0 write: wb_inst=0 with wb_valid=1 -> no commit. wb_wen=1 with wb_wdest=0 -> commit_wen=0, commit_wdest=8'h00.
- Self-loop re-entry, DEDUP=1: pc 0x80000020 accepted, then wb_valid=0 for one cycle, then same pc again -> second commit issued.
- Trap: accept inst 0x0000006b at pc 0x80000100 with a0_value=0 -> trap_valid=1, trap_code=0, trap_pc=0x80000100. Afterwards counters freeze and further wb_valid input produces no commits.
- Reset while HALT and mid-stream: assert reset one cycle -> all outputs 0 next cycle; a new instruction is accepted normally, and its pc is not treated as a duplicate.
